// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/ack bus between the MEM stage and data memory
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_wen;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: load/store launch, stall control, load alignment
module mem_access_stage (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       MemRead_in,
  input  logic                       MemWrite_in,
  input  logic                       RegWrite_in,
  input  logic                       MemtoReg_in,
  input  logic [2:0]                 funct3_in,
  input  logic [31:0]                alu_result_in,
  input  logic [31:0]                store_data_in,
  input  logic [4:0]                 Rd_in,
  mem_access_stage_if.master         mem,
  output logic                       stall,
  output logic                       misalign_err,
  output logic                       RegWrite_out,
  output logic                       MemtoReg_out,
  output logic [31:0]                data_ALU_out,
  output logic [31:0]                data_mem_out,
  output logic [4:0]                 Rd_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wen_q, mem_wen_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] load_q, load_d;

  logic        access, f3_ok, aligned, legal, illegal;
  logic [1:0]  a_lo;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign a_lo   = alu_result_in[1:0];
  assign access = MemRead_in | MemWrite_in;

  always_comb begin
    f3_ok   = 1'b0;
    aligned = 1'b1;
    if (MemWrite_in)
      f3_ok = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010);
    else
      f3_ok = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
              (funct3_in == 3'b100) || (funct3_in == 3'b101);
    case (funct3_in[1:0])
      2'b01:   aligned = ~a_lo[0];
      2'b10:   aligned = (a_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign legal   = access & f3_ok & aligned;
  assign illegal = access & ~legal;

  // Stores replicate the datum across every lane so memory only needs the mask.
  always_comb begin
    st_wdata = store_data_in;
    st_wmask = 4'b0000;
    case (funct3_in[1:0])
      2'b00: begin
        st_wdata = {4{store_data_in[7:0]}};
        st_wmask = 4'b0001 << a_lo;
      end
      2'b01: begin
        st_wdata = {2{store_data_in[15:0]}};
        st_wmask = 4'b0011 << a_lo;
      end
      default: begin
        st_wdata = store_data_in;
        st_wmask = 4'b1111;
      end
    endcase
    if (!MemWrite_in)
      st_wmask = 4'b0000;
  end

  always_comb begin
    ld_byte = mem.mem_rdata[7:0];
    case (a_lo)
      2'b00:   ld_byte = mem.mem_rdata[7:0];
      2'b01:   ld_byte = mem.mem_rdata[15:8];
      2'b10:   ld_byte = mem.mem_rdata[23:16];
      default: ld_byte = mem.mem_rdata[31:24];
    endcase
    ld_half = a_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (funct3_in)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 30'h0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'h0;
      load_q      <= 32'h0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      load_q      <= load_d;
    end
  end

  // The instruction stays parked at the inputs through DONE, so DONE must not relaunch it.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    load_d       = load_q;
    stall        = 1'b0;
    misalign_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          stall       = 1'b1;
          mem_req_d   = 1'b1;
          mem_wen_d   = MemWrite_in;
          mem_addr_d  = alu_result_in[31:2];
          mem_wdata_d = st_wdata;
          mem_wmask_d = st_wmask;
          state_d     = BUSY;
        end else if (illegal) begin
          misalign_err = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          load_d    = ld_data;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_wen   = mem_wen_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wmask = mem_wmask_q;

  assign RegWrite_out = RegWrite_in & ~stall & ~illegal;
  assign MemtoReg_out = MemtoReg_in;
  assign data_ALU_out = alu_result_in;
  assign data_mem_out = load_q;
  assign Rd_out       = Rd_in;

endmodule
